// File: rtl/flush_redirect_ctrl_pkg.sv
// ============================================================================
// flush_redirect_ctrl_pkg : shared types for the flush/redirect controller
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package flush_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam int unsigned c_OUTSTANDING_MAX_DEF = 2;
    localparam int unsigned c_CNT_W_DEF           = 2;
    localparam int unsigned c_PC_W                = 32;
    localparam int unsigned c_REDIRECT_W          = c_PC_W + 1;

    // {redirect_valid, redirect_pc}, c_REDIRECT_W bits wide
    typedef struct packed {
        logic              valid;
        logic [c_PC_W-1:0] pc;
    } redirect_t;

endpackage

`default_nettype wire

// File: rtl/flush_redirect_ctrl_inflight_counter.sv
// ============================================================================
// flush_redirect_ctrl_inflight_counter : saturating up/down request counter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_redirect_ctrl_inflight_counter #(
    parameter int unsigned MAX = 2,
    parameter int unsigned W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_next_o,
    output logic         overflow_o,
    output logic         underflow_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        overflow_o  = inc_i & ~dec_i & (count_q == W'(MAX));
        underflow_o = dec_i & ~inc_i & (count_q == '0);
        count_d     = count_q;
        if (inc_i && !dec_i && !overflow_o) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && !underflow_o) begin
            count_d = count_q - W'(1);
        end
    end

    assign count_next_o = count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count saturates; these flag a fetch-protocol bug upstream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!overflow_o);
            assert (!underflow_o);
        end
    end

endmodule

`default_nettype wire

// File: rtl/flush_redirect_ctrl.sv
// ============================================================================
// flush_redirect_ctrl : flush broadcast, stale-fetch drain and single redirect
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_redirect_ctrl
    import flush_redirect_ctrl_pkg::*;
#(
    parameter int unsigned OUTSTANDING_MAX = c_OUTSTANDING_MAX_DEF,
    parameter int unsigned CNT_W           = c_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic        wb_ertn,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ex_era,
    input  logic        ifetch_req_fire,
    input  logic        ifetch_resp_fire,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        discard_resp,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [31:0]        target_q, target_d;
    logic [CNT_W-1:0]   w_inflight_next;
    logic               w_ovf, w_unf;
    logic               w_event;
    redirect_t          w_redir;

    flush_redirect_ctrl_inflight_counter #(
        .MAX (OUTSTANDING_MAX),
        .W   (CNT_W)
    ) u_inflight (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (ifetch_req_fire),
        .dec_i        (ifetch_resp_fire),
        .count_next_o (w_inflight_next),
        .overflow_o   (w_ovf),
        .underflow_o  (w_unf)
    );

    // Outside IDLE the WB stage is already flushed, so events there are stale.
    assign w_event      = (state_q == ST_IDLE) & (wb_ex | wb_ertn);
    assign flush        = w_event | (state_q != ST_IDLE);
    assign discard_resp = ifetch_resp_fire & (w_event | (state_q == ST_DRAIN));
    assign busy         = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        target_d = target_q;
        w_redir  = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_event) begin
                    drain_d  = w_inflight_next;
                    target_d = wb_ertn ? ex_era : ex_entry;
                    state_d  = (w_inflight_next == '0) ? ST_REDIRECT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ifetch_resp_fire) begin
                    drain_d = drain_q - CNT_W'(1);
                    if (drain_q == CNT_W'(1)) begin
                        state_d = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                w_redir.valid = 1'b1;
                w_redir.pc    = target_q;
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign redirect_valid = w_redir.valid;
    assign redirect_pc    = w_redir.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            drain_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            target_q <= target_d;
        end
    end

    // IF must gate issue on flush, and nothing may return once drained.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!((state_q == ST_DRAIN) && ifetch_req_fire));
            assert (!((state_q == ST_REDIRECT) && ifetch_resp_fire));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flush_redirect_ctrl.sv
// ============================================================================
// tb_flush_redirect_ctrl : vector table, corner sequences and random vs model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flush_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_ex, wb_ertn;
    logic [31:0] ex_entry, ex_era;
    logic        ifetch_req_fire, ifetch_resp_fire, redirect_ready;
    logic        flush, discard_resp, redirect_valid, busy;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    flush_redirect_ctrl #(
        .OUTSTANDING_MAX (2),
        .CNT_W           (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_ex            (wb_ex),
        .wb_ertn          (wb_ertn),
        .ex_entry         (ex_entry),
        .ex_era           (ex_era),
        .ifetch_req_fire  (ifetch_req_fire),
        .ifetch_resp_fire (ifetch_resp_fire),
        .redirect_ready   (redirect_ready),
        .flush            (flush),
        .discard_resp     (discard_resp),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ex, ertn;
        logic [31:0] entry, era;
        logic        req, resp, rdy, chk;
        logic        e_flush, e_disc, e_rv;
        logic [31:0] e_pc;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, ex, ertn, input logic [31:0] entry, era,
                                input logic req, resp, rdy, chk,
                                input logic f, d, rv, input logic [31:0] pc, input logic b);
        vec_t v;
        v.rst = rst; v.ex = ex; v.ertn = ertn; v.entry = entry; v.era = era;
        v.req = req; v.resp = resp; v.rdy = rdy; v.chk = chk;
        v.e_flush = f; v.e_disc = d; v.e_rv = rv; v.e_pc = pc; v.e_busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ex, ertn, input logic [31:0] entry, era,
                         input logic req, resp, rdy);
        reset = rst; wb_ex = ex; wb_ertn = ertn; ex_entry = entry; ex_era = era;
        ifetch_req_fire = req; ifetch_resp_fire = resp; redirect_ready = rdy;
    endtask

    task automatic expect_all(input string tag, input logic f, d, rv,
                              input logic [31:0] pc, input logic b);
        @(negedge clk);
        check({tag, ".flush"},   {31'd0, flush},          {31'd0, f});
        check({tag, ".discard"}, {31'd0, discard_resp},   {31'd0, d});
        check({tag, ".rvalid"},  {31'd0, redirect_valid}, {31'd0, rv});
        check({tag, ".rpc"},     redirect_pc,             pc);
        check({tag, ".busy"},    {31'd0, busy},           {31'd0, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: outstanding fetches, how many of them are stale, and whether a
    // flush episode is open; the redirect is due once no stale fetch remains.
    int          m_out, m_stale;
    bit          m_active;
    logic [31:0] m_tgt;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 0,0,0,32'h0,0));
        // single exception, nothing in flight
        vecs.push_back(mk(0,1,0,32'h1c008000,0,          0,0,0,1, 1,0,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,1,1, 1,0,1,32'h1c008000,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 0,0,0,32'h0,0));
        // ertn with two fetches in flight
        vecs.push_back(mk(0,0,0,0,0,                     1,0,0,1, 0,0,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,                     1,0,0,1, 0,0,0,32'h0,0));
        vecs.push_back(mk(0,0,1,32'h0,32'h1c000100,      0,0,0,1, 1,0,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 1,0,0,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 1,0,0,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,1,0,1, 1,1,0,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 1,0,0,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,1,0,1, 1,1,0,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,1,1, 1,0,1,32'h1c000100,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 0,0,0,32'h0,0));
        // ex and ertn together: ERA wins
        vecs.push_back(mk(0,1,1,32'h1c008000,32'h1c000200,0,0,0,1, 1,0,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,1,1, 1,0,1,32'h1c000200,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 0,0,0,32'h0,0));
        // response in the event cycle is discarded and drains the last fetch
        vecs.push_back(mk(0,0,0,0,0,                     1,0,0,1, 0,0,0,32'h0,0));
        vecs.push_back(mk(0,1,0,32'h1c00a000,0,          0,1,0,1, 1,1,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,1,1, 1,0,1,32'h1c00a000,1));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,1, 0,0,0,32'h0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ex, vecs[i].ertn, vecs[i].entry, vecs[i].era,
                  vecs[i].req, vecs[i].resp, vecs[i].rdy);
            if (vecs[i].chk)
                expect_all($sformatf("vec%0d", i), vecs[i].e_flush, vecs[i].e_disc,
                           vecs[i].e_rv, vecs[i].e_pc, vecs[i].e_busy);
            tick();
        end

        // request fired in the event cycle must also be drained
        drive(0,0,0,0,0,1,0,0);           expect_all("t4_req",   0,0,0,32'h0,0); tick();
        drive(0,1,0,32'h1c008000,0,1,0,0); expect_all("t4_evt",  1,0,0,32'h0,0); tick();
        drive(0,0,0,0,0,0,1,0);           expect_all("t4_r1",    1,1,0,32'h0,1); tick();
        drive(0,0,0,0,0,0,0,0);           expect_all("t4_gap",   1,0,0,32'h0,1); tick();
        drive(0,0,0,0,0,0,1,0);           expect_all("t4_r2",    1,1,0,32'h0,1); tick();
        drive(0,0,0,0,0,0,0,1);           expect_all("t4_redir", 1,0,1,32'h1c008000,1); tick();
        drive(0,0,0,0,0,0,0,0);           expect_all("t4_idle",  0,0,0,32'h0,0); tick();

        // redirect back-pressure with ignored exception pulses
        drive(0,1,0,32'h1c004000,0,0,0,0); expect_all("t5_evt",  1,0,0,32'h0,0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0,1,1,32'h1c00dead,32'h1c00beef,0,0,0);
            expect_all($sformatf("t5_wait%0d", i), 1,0,1,32'h1c004000,1);
            tick();
        end
        drive(0,0,0,0,0,0,0,1);           expect_all("t5_acc",   1,0,1,32'h1c004000,1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,0,0,0,0,1);
            expect_all($sformatf("t5_after%0d", i), 0,0,0,32'h0,0);
            tick();
        end

        // reset while draining two stale fetches
        drive(0,0,0,0,0,1,0,0);           tick();
        drive(0,0,0,0,0,1,0,0);           tick();
        drive(0,1,0,32'h1c006000,0,0,0,0); expect_all("t6_evt",  1,0,0,32'h0,0); tick();
        drive(0,0,0,0,0,0,0,0);           expect_all("t6_drain", 1,0,0,32'h0,1); tick();
        drive(1,0,0,0,0,0,0,0);           tick();
        drive(0,0,0,0,0,0,0,0);           expect_all("t6_rst",   0,0,0,32'h0,0); tick();
        drive(0,1,0,32'h1c007000,0,0,0,0); expect_all("t6_evt2", 1,0,0,32'h0,0); tick();
        drive(0,0,0,0,0,0,0,1);           expect_all("t6_redir", 1,0,1,32'h1c007000,1); tick();
        drive(0,0,0,0,0,0,0,0);           expect_all("t6_idle",  0,0,0,32'h0,0); tick();

        // protocol-legal random traffic against the reference
        m_out = 0; m_stale = 0; m_active = 0; m_tgt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic rst, ex, ertn, req, resp, rdy, evt, due;
            logic [31:0] entry, era;
            rst   = ($urandom_range(0, 199) == 0);
            ex    = ($urandom_range(0, 7) == 0);
            ertn  = ($urandom_range(0, 7) == 0);
            entry = $urandom & 32'hffff_fffc;
            era   = $urandom & 32'hffff_fffc;
            due   = m_active && (m_stale == 0);
            resp  = (m_out > 0) && !due && ($urandom_range(0, 1) == 1);
            req   = !m_active && ((m_out < 2) || resp) && ($urandom_range(0, 1) == 1);
            rdy   = ($urandom_range(0, 1) == 1);
            drive(rst, ex, ertn, entry, era, req, resp, rdy);

            evt = !m_active && (ex || ertn);
            expect_all($sformatf("rnd%0d", cyc), evt || m_active,
                       resp && (evt || (m_active && m_stale > 0)),
                       due, due ? m_tgt : 32'h0, m_active);

            if (rst) begin
                m_out = 0; m_stale = 0; m_active = 0; m_tgt = '0;
            end else begin
                if (evt) begin
                    m_active = 1;
                    m_stale  = m_out + int'(req) - int'(resp);
                    m_tgt    = ertn ? era : entry;
                end else if (m_active && m_stale > 0) begin
                    if (resp) m_stale--;
                end else if (due && rdy) begin
                    m_active = 0;
                end
                m_out = m_out + int'(req) - int'(resp);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
